// File: rtl/pc_fetch_pkg.sv
// Shared types and helpers for the PC fetch unit: FSM states, branch/jump opcodes and
// B/J immediate extraction used by the optional static predictor (PC_STATIC_PREDICT_EN).
package pc_fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_FLUSH
  } fetch_state_e;

  localparam logic [6:0] SB_JUMP_Op = 7'b1100011;
  localparam logic [6:0] UJ_Op      = 7'b1101111;

  // B-format immediate, sign-extended to 32 bits.
  function automatic logic [31:0] imm_b(input logic [31:0] instr);
    return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  endfunction

  // J-format immediate, sign-extended to 32 bits.
  function automatic logic [31:0] imm_j(input logic [31:0] instr);
    return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue: synchronous FIFO with flush and occupancy count.
// Depth must be a power of two so the pointers wrap naturally.
module fetch_fifo #(
  parameter int unsigned Width = 65,
  parameter int unsigned Depth = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    flush_i,
  input  logic                    push_i,
  input  logic [Width-1:0]        wdata_i,
  input  logic                    pop_i,
  output logic [Width-1:0]        rdata_o,
  output logic                    valid_o,
  output logic [$clog2(Depth):0]  count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign valid_o = (count_q != '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];
  assign do_push = push_i && !flush_i && (count_q != DepthCnt);
  assign do_pop  = pop_i && !flush_i && valid_o;

  // Pointer and count next-state; flush empties the queue in one edge.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + PtrW'(1);
      if (do_pop)  rptr_d = rptr_q + PtrW'(1);
      if (do_push && !do_pop)      count_d = count_q + CntW'(1);
      else if (!do_push && do_pop) count_d = count_q - CntW'(1);
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset; entries are only observed once counted valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC sequencer with one-outstanding imem handshake, prefetch queue and redirect-with-flush.
// Define PC_STATIC_PREDICT_EN to follow backward branches and JALs at fetch time.
module pc_fetch_unit import pc_fetch_pkg::*; #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [31:0] RESET_VEC  = 32'h4
) (
  input  logic            clock,
  input  logic            rst,
  input  logic            i_redirect_cs,
  input  logic [XLEN-1:0] i_redirect_addr,
  input  logic            i_hold,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_gnt,
  input  logic            i_imem_rvalid,
  input  logic [31:0]     i_imem_rdata,
  output logic            o_instr_valid,
  output logic [31:0]     o_instr,
  output logic [XLEN-1:0] o_instr_addr,
  output logic            o_pred_taken,
  input  logic            i_instr_ready
);

  localparam int unsigned EntryW = 32 + XLEN + 1;
  localparam int unsigned CntW   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(FIFO_DEPTH);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] next_pc;
  logic            pred_taken;
  logic            push, flush, pop;
  logic            head_valid;
  logic [EntryW-1:0] head;
  logic [CntW-1:0]   count;

`ifdef PC_STATIC_PREDICT_EN
  logic [6:0] opcode;
  // Static prediction: backward conditional branches and all JALs are taken.
  always_comb begin
    opcode     = i_imem_rdata[6:0];
    pred_taken = 1'b0;
    next_pc    = pc_q + XLEN'(4);
    if (opcode == UJ_Op) begin
      pred_taken = 1'b1;
      next_pc    = pc_q + XLEN'($signed(imm_j(i_imem_rdata)));
    end else if (opcode == SB_JUMP_Op && i_imem_rdata[31]) begin
      pred_taken = 1'b1;
      next_pc    = pc_q + XLEN'($signed(imm_b(i_imem_rdata)));
    end
  end
`else
  assign next_pc    = pc_q + XLEN'(4);
  assign pred_taken = 1'b0;
`endif

  // Only request while a queue slot is free, so a response can always be enqueued.
  assign o_imem_req  = (state_q == S_REQ) && (count < DepthCnt);
  assign o_imem_addr = o_imem_req ? pc_q : '0;
  assign pop         = head_valid && i_instr_ready && !i_hold;

  // Next-state: redirect overrides everything and decides whether a stale response is pending.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push    = 1'b0;
    flush   = 1'b0;
    if (i_redirect_cs) begin
      flush = 1'b1;
      pc_d  = {i_redirect_addr[XLEN-1:2], 2'b00};
      case (state_q)
        S_WAIT:  state_d = i_imem_rvalid ? S_REQ : S_FLUSH;
        S_REQ:   state_d = (o_imem_req && i_imem_gnt) ? S_FLUSH : S_REQ;
        default: state_d = S_REQ;
      endcase
    end else begin
      case (state_q)
        S_IDLE: state_d = S_REQ;
        S_REQ:  if (o_imem_req && i_imem_gnt) state_d = S_WAIT;
        S_WAIT: begin
          if (i_imem_rvalid) begin
            push    = 1'b1;
            pc_d    = next_pc;
            state_d = S_REQ;
          end
        end
        S_FLUSH: if (i_imem_rvalid) state_d = S_REQ;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and PC registers.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= XLEN'(RESET_VEC);
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  fetch_fifo #(
    .Width (EntryW),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clock),
    .rst_i   (rst),
    .flush_i (flush),
    .push_i  (push),
    .wdata_i ({i_imem_rdata, pc_q, pred_taken}),
    .pop_i   (pop),
    .rdata_o (head),
    .valid_o (head_valid),
    .count_o (count)
  );

  // Head fields read as zero when the queue is empty.
  assign o_instr_valid = head_valid;
  assign o_instr       = head_valid ? head[EntryW-1 -: 32] : '0;
  assign o_instr_addr  = head_valid ? head[XLEN:1] : '0;
  assign o_pred_taken  = head_valid ? head[0] : 1'b0;

endmodule
